// File: rtl/eth_pkg.sv
// Shared constants, FSM encoding and helpers for the Ethernet MAC receive and transmit paths.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [47:0] ETH_BCAST_ADDR  = 48'hFFFFFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } eth_rx_state_e;

  // The residue constant is written MSB-first; a reflected CRC register holds it bit-reversed.
  function automatic logic [31:0] eth_bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected polynomial, LSB first); shared by RX and TX.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'd0, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/eth_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks FCS and length, forwards payload with status.
// Optional destination-address filtering is enabled by defining ETH_RX_ADDR_FILTER_EN.
module eth_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
`ifdef ETH_RX_ADDR_FILTER_EN
  ,
  parameter logic [47:0] MAC_ADDR = 48'h000A35000001
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  eth_rx_d_in,
  input  logic        eth_rx_dv_in,
  input  logic        eth_rx_err_in,
  output logic [7:0]  rx_d_out,
  output logic        rx_valid_out,
  output logic        rx_sof_out,
  output logic        rx_eof_out,
  output logic        rx_good_out,
  output logic        rx_bad_out,
  output logic [10:0] rx_len_out,
  output logic [15:0] rx_drop_cnt_out
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  eth_rx_state_e state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [10:0] cnt_q, cnt_d;
  logic [39:0] dly_q, dly_d;
  logic        err_q, err_d;
  logic [7:0]  d_q, d_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic [10:0] len_q, len_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        addr_ok;
  logic        residue_ok;
  logic        len_ok;

  eth_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (eth_rx_d_in),
    .crc_out (crc_next)
  );

  // The destination MAC is complete when its 6th byte sits on the input next to the 5 delayed bytes.
`ifdef ETH_RX_ADDR_FILTER_EN
  assign addr_ok = ({dly_q, eth_rx_d_in} == MAC_ADDR) || ({dly_q, eth_rx_d_in} == ETH_BCAST_ADDR);
`else
  assign addr_ok = 1'b1;
`endif

  assign residue_ok = (eth_bitrev32(crc_q) == ETH_CRC_RESIDUE);
  assign len_ok     = (cnt_q >= MIN_L) && (cnt_q <= MAX_L) && (cnt_q >= 11'd5);

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    err_d      = err_q;
    d_d        = d_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    len_d      = len_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (eth_rx_dv_in) begin
          if (eth_rx_d_in == ETH_PREAMBLE) begin
            state_d = ST_PREAMBLE;
          end else if (eth_rx_d_in == ETH_SFD) begin
            state_d = ST_DATA;
            crc_d   = ETH_CRC_INIT;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!eth_rx_dv_in) begin
          state_d = ST_IDLE;
        end else if (eth_rx_d_in == ETH_SFD) begin
          state_d = ST_DATA;
          crc_d   = ETH_CRC_INIT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (eth_rx_d_in != ETH_PREAMBLE) begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (eth_rx_dv_in) begin
          if (cnt_q == MAX_L) begin
            eof_d   = 1'b1;
            bad_d   = 1'b1;
            state_d = ST_DROP;
          end else begin
            crc_d = crc_next;
            dly_d = {dly_q[31:0], eth_rx_d_in};
            cnt_d = cnt_q + 11'd1;
            if (eth_rx_err_in) begin
              err_d = 1'b1;
            end
            if (cnt_q >= 11'd5) begin
              if ((cnt_q == 11'd5) && !addr_ok) begin
                state_d = ST_DROP;
              end else begin
                valid_d = 1'b1;
                d_d     = dly_q[39:32];
                sof_d   = (cnt_q == 11'd5);
              end
            end
          end
        end else begin
          // Frame end: the four bytes left in the delay line are the FCS and never leave.
          eof_d   = 1'b1;
          len_d   = cnt_q - 11'd4;
          state_d = ST_IDLE;
          if (cnt_q >= 11'd5) begin
            valid_d = 1'b1;
            d_d     = dly_q[39:32];
            sof_d   = (cnt_q == 11'd5);
          end
          if (residue_ok && !err_q && len_ok) begin
            good_d = 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (!eth_rx_dv_in) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (bad_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= ETH_CRC_INIT;
      cnt_q      <= '0;
      dly_q      <= '0;
      err_q      <= 1'b0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      len_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      err_q      <= err_d;
      d_q        <= d_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      len_q      <= len_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_d_out        = d_q;
  assign rx_valid_out    = valid_q;
  assign rx_sof_out      = sof_q;
  assign rx_eof_out      = eof_q;
  assign rx_good_out     = good_q;
  assign rx_bad_out      = bad_q;
  assign rx_len_out      = len_q;
  assign rx_drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Self-checking bench for eth_rx_deframer: a frame-level model predicts every output event and its cycle.
// Frame-filter cases are added when ETH_RX_ADDR_FILTER_EN is defined.
module tb_eth_rx_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam logic [47:0] OWN_MAC = 48'h000A35000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxDIn;
  logic        rxDvIn;
  logic        rxErrIn;
  logic [7:0]  rxD;
  logic        rxValid;
  logic        rxSof;
  logic        rxEof;
  logic        rxGood;
  logic        rxBad;
  logic [10:0] rxLen;
  logic [15:0] rxDropCnt;

  eth_rx_deframer dut (
    .clk             (clk),
    .rst             (rst),
    .eth_rx_d_in     (rxDIn),
    .eth_rx_dv_in    (rxDvIn),
    .eth_rx_err_in   (rxErrIn),
    .rx_d_out        (rxD),
    .rx_valid_out    (rxValid),
    .rx_sof_out      (rxSof),
    .rx_eof_out      (rxEof),
    .rx_good_out     (rxGood),
    .rx_bad_out      (rxBad),
    .rx_len_out      (rxLen),
    .rx_drop_cnt_out (rxDropCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    bit          valid;
    bit          sof;
    bit          eof;
    bit          good;
    bit          bad;
    bit          chkLen;
    logic [7:0]  d;
    logic [10:0] len;
    logic [15:0] drop;
  } expEvent_t;

  expEvent_t   expQ[$];
  expEvent_t   curEv;
  int          cyc = 0;
  int          numCompared = 0;
  int          numMismatched = 0;
  logic [7:0]  frame [0:1599];
  int          expDrop = 0;
  int          obsValid = 0;
  int          obsEof = 0;
  int          obsSof = 0;
  bit          lastGood;
  bit          lastBad;
  logic [10:0] lastLen;
  bit          checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference CRC-32 over frame[0..len-1], returned as the value carried in the FCS.
  function automatic logic [31:0] refCrc(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'd0, frame[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic buildFrame(input int plen, input logic [47:0] dest, input int seed, input bit flipFcs, output int n);
    logic [31:0] fcs;
    logic [7:0]  v;
    for (int i = 0; i < 6; i++) frame[i] = dest[47-8*i -: 8];
    for (int i = 6; i < plen; i++) begin
      v = 8'(i * 7 + seed);
      if (v == 8'h55 || v == 8'hD5) v = v + 8'd1;
      frame[i] = v;
    end
    fcs = refCrc(plen);
    for (int b = 0; b < 4; b++) frame[plen+b] = fcs[8*b +: 8];
    if (flipFcs) frame[plen] = frame[plen] ^ 8'h01;
    n = plen + 4;
  endtask

  task automatic pushEvent(input int stamp, input bit valid, input bit sof, input bit eof, input bit good,
                           input logic [7:0] d, input bit chkLen, input logic [10:0] len);
    expEvent_t e;
    e.stamp  = stamp;
    e.valid  = valid;
    e.sof    = sof;
    e.eof    = eof;
    e.good   = good;
    e.bad    = eof && !good;
    e.d      = d;
    e.chkLen = chkLen;
    e.len    = len;
    if (e.bad) expDrop++;
    e.drop   = 16'(expDrop);
    expQ.push_back(e);
  endtask

  // Frame-level model: s0 is the edge that samples the first byte after the SFD.
  task automatic predictFrame(input int s0, input int n, input bit errSeen);
    bit fcsOk;
    bit good;
`ifdef ETH_RX_ADDR_FILTER_EN
    logic [47:0] dest;
    if (n >= 6) begin
      dest = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
      if (dest != OWN_MAC && dest != 48'hFFFFFFFFFFFF) return;
    end
`endif
    if (n > MAX_LEN) begin
      for (int j = 5; j < MAX_LEN; j++) pushEvent(s0 + j, 1, j == 5, 0, 0, frame[j-5], 0, 11'd0);
      pushEvent(s0 + MAX_LEN, 0, 0, 1, 0, 8'd0, 0, 11'd0);
      return;
    end
    for (int j = 5; j < n; j++) pushEvent(s0 + j, 1, j == 5, 0, 0, frame[j-5], 0, 11'd0);
    fcsOk = (n >= 4) && ({frame[n-1], frame[n-2], frame[n-3], frame[n-4]} == refCrc(n - 4));
    good  = fcsOk && !errSeen && (n >= MIN_LEN) && (n <= MAX_LEN) && (n >= 5);
    pushEvent(s0 + n, n >= 5, n == 5, 1, good, (n >= 5) ? frame[n-5] : 8'd0, n >= 4, 11'(n - 4));
  endtask

  task automatic drive(input bit dv, input logic [7:0] d, input bit err);
    @(negedge clk);
    rst     = 1'b0;
    rxDvIn  = dv;
    rxDIn   = d;
    rxErrIn = err;
  endtask

  task automatic applyStimulus(input int n, input int errIdx, input int rstIdx);
    bit errSeen;
    errSeen = (errIdx >= 0) && (errIdx < n) && (errIdx < MAX_LEN);
    repeat (7) drive(1, 8'h55, 0);
    drive(1, 8'hD5, 0);
    for (int k = 0; k < n; k++) begin
      drive(1, frame[k], k == errIdx);
      if (k == 0) predictFrame(cyc + 1, n, errSeen);
      if (k == rstIdx) begin
        rst = 1'b1;
        expQ.delete();
        expDrop = 0;
        #1;
        checkOutput("midrst_valid", rxValid, 0);
        checkOutput("midrst_sof", rxSof, 0);
        checkOutput("midrst_eof", rxEof, 0);
        checkOutput("midrst_good", rxGood, 0);
        checkOutput("midrst_bad", rxBad, 0);
        checkOutput("midrst_d", rxD, 0);
        checkOutput("midrst_len", rxLen, 0);
        checkOutput("midrst_drop", rxDropCnt, 0);
      end
    end
    drive(0, 8'h00, 0);
  endtask

  task automatic settle();
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    #1;
  endtask

  // Cycle-by-cycle comparison against the model's event queue.
  initial begin
    forever begin
      @(negedge clk);
      if (checking && !rst) begin
        if (rxValid) obsValid++;
        if (rxValid && rxSof) obsSof++;
        if (rxEof) begin
          obsEof++;
          lastGood = rxGood;
          lastBad  = rxBad;
          lastLen  = rxLen;
        end
        while (expQ.size() > 0 && expQ[0].stamp < cyc) begin
          checkOutput("missed_event", cyc, expQ[0].stamp);
          void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].stamp == cyc) begin
          curEv = expQ.pop_front();
          checkOutput("valid", rxValid, curEv.valid);
          checkOutput("sof", rxSof, curEv.sof);
          checkOutput("eof", rxEof, curEv.eof);
          checkOutput("good", rxGood, curEv.good);
          checkOutput("bad", rxBad, curEv.bad);
          if (curEv.valid) checkOutput("data", rxD, curEv.d);
          if (curEv.eof && curEv.chkLen) checkOutput("len", rxLen, curEv.len);
          if (curEv.eof) checkOutput("drop_cnt", rxDropCnt, curEv.drop);
        end else begin
          checkOutput("idle_flags", {27'd0, rxValid, rxSof, rxEof, rxGood, rxBad}, 0);
        end
      end
    end
  end

  initial begin
    int n;
    int v0;
    int e0;
    int s0;
    rst     = 1'b1;
    rxDvIn  = 1'b0;
    rxDIn   = 8'h00;
    rxErrIn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_valid", rxValid, 0);
    checkOutput("reset_eof", rxEof, 0);
    checkOutput("reset_sof", rxSof, 0);
    checkOutput("reset_good_bad", {rxGood, rxBad}, 0);
    checkOutput("reset_d", rxD, 0);
    checkOutput("reset_len", rxLen, 0);
    checkOutput("reset_drop", rxDropCnt, 0);

    for (int i = 0; i < 9; i++) frame[i] = 8'(8'h31 + i);
    checkOutput("model_crc_123456789", refCrc(9), 32'hCBF43926);

    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;

    $display("[TB] good 60-byte frame");
    buildFrame(60, OWN_MAC, 3, 0, n);
    v0 = obsValid; e0 = obsEof; s0 = obsSof;
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("t1_valid_count", obsValid - v0, 60);
    checkOutput("t1_sof_count", obsSof - s0, 1);
    checkOutput("t1_eof_count", obsEof - e0, 1);
    checkOutput("t1_good", lastGood, 1);
    checkOutput("t1_len", lastLen, 60);
    checkOutput("t1_drop", rxDropCnt, 0);

    $display("[TB] FCS bit flipped");
    buildFrame(60, OWN_MAC, 3, 1, n);
    v0 = obsValid;
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("t2_valid_count", obsValid - v0, 60);
    checkOutput("t2_bad", lastBad, 1);
    checkOutput("t2_drop", rxDropCnt, 1);

    $display("[TB] rx error then back-to-back clean frame");
    buildFrame(60, OWN_MAC, 9, 0, n);
    e0 = obsEof;
    applyStimulus(n, 20, -1);
    buildFrame(60, OWN_MAC, 17, 0, n);
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("t3_eof_count", obsEof - e0, 2);
    checkOutput("t3_last_good", lastGood, 1);
    checkOutput("t3_drop", rxDropCnt, 2);

    $display("[TB] runt and 3-byte frame");
    buildFrame(40, OWN_MAC, 21, 0, n);
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("t4_runt_bad", lastBad, 1);
    checkOutput("t4_runt_len", lastLen, 40);
    checkOutput("t4_runt_drop", rxDropCnt, 3);
    frame[0] = 8'h00; frame[1] = 8'h0A; frame[2] = 8'h35;
    v0 = obsValid; e0 = obsEof;
    applyStimulus(3, -1, -1);
    settle();
    checkOutput("t4_tiny_valid", obsValid - v0, 0);
    checkOutput("t4_tiny_eof", obsEof - e0, 1);
    checkOutput("t4_tiny_bad", lastBad, 1);
    checkOutput("t4_tiny_drop", rxDropCnt, 4);

    $display("[TB] oversize 1600-byte frame");
    buildFrame(1596, OWN_MAC, 5, 0, n);
    v0 = obsValid; e0 = obsEof;
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("t5_valid_count", obsValid - v0, 1513);
    checkOutput("t5_eof_count", obsEof - e0, 1);
    checkOutput("t5_bad", lastBad, 1);
    checkOutput("t5_drop", rxDropCnt, 5);

    $display("[TB] reset mid-frame then clean frame");
    buildFrame(60, OWN_MAC, 11, 0, n);
    e0 = obsEof;
    applyStimulus(n, -1, 30);
    settle();
    checkOutput("t6_no_eof", obsEof - e0, 0);
    checkOutput("t6_drop_cleared", rxDropCnt, 0);
    buildFrame(60, OWN_MAC, 13, 0, n);
    v0 = obsValid;
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("t6_next_valid", obsValid - v0, 60);
    checkOutput("t6_next_good", lastGood, 1);
    checkOutput("t6_next_drop", rxDropCnt, 0);

`ifdef ETH_RX_ADDR_FILTER_EN
    $display("[TB] address filter");
    buildFrame(60, 48'h0A0B0C0D0E0F, 7, 0, n);
    v0 = obsValid; e0 = obsEof;
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("flt_wrong_valid", obsValid - v0, 0);
    checkOutput("flt_wrong_eof", obsEof - e0, 0);
    checkOutput("flt_wrong_drop", rxDropCnt, 0);
    buildFrame(60, 48'hFFFFFFFFFFFF, 7, 0, n);
    v0 = obsValid;
    applyStimulus(n, -1, -1);
    settle();
    checkOutput("flt_bcast_valid", obsValid - v0, 60);
    checkOutput("flt_bcast_good", lastGood, 1);
`endif

    repeat (8) drive(0, 8'h00, 0);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/eth_rx_deframer.md
Name: eth_rx_deframer

Overview:
Receive-side front end of the Ethernet MAC. It takes the raw GMII byte stream (data, dv, err) already in the clk domain and strips the preamble and SFD. It checks the frame's CRC-32 and length, and forwards payload bytes (destination MAC through the last byte before the FCS) with frame-boundary markers and a good/bad verdict. The frame buffer / memory-write stage toward the MCB consumes its output.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (destination MAC through FCS inclusive)
MAX_LEN, 1518, maximum legal frame length in bytes (destination MAC through FCS inclusive)
MAC_ADDR, 48'h000A35000001, local unicast address; used only when the filter macro is enabled

Ports:
clk  in  1  receive clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
eth_rx_d_in  in  8  GMII receive data
eth_rx_dv_in  in  1  GMII data valid
eth_rx_err_in  in  1  GMII receive error
rx_d_out  out  8  payload byte
rx_valid_out  out  1  rx_d_out is valid this cycle
rx_sof_out  out  1  first payload byte of the frame (qualified by rx_valid_out)
rx_eof_out  out  1  frame end; coincides with the last byte, or stands alone on an abort
rx_good_out  out  1  frame accepted; asserted only together with rx_eof_out
rx_bad_out  out  1  frame rejected; asserted only together with rx_eof_out
rx_len_out  out  11  payload byte count excluding FCS; valid while rx_eof_out=1
rx_drop_cnt_out  out  16  count of frames that ended with rx_bad_out; saturates at 16'hFFFF

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. CRC register = 32'hFFFFFFFF. Byte count and delay line are cleared.
- All outputs are registered and change only on the rising edge of clk.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - dv=1 and d=8'h55 -> PREAMBLE.
  - dv=1 and d=8'hD5 -> DATA (short preamble accepted).
  - dv=1 and any other byte -> DROP.
- PREAMBLE:
  - d=8'h55 -> stay in PREAMBLE.
  - d=8'hD5 -> DATA.
  - dv=0 -> IDLE, no status.
  - Any other byte -> DROP.
- Entering DATA: CRC register = 32'hFFFFFFFF, byte count = 0.
- DATA, each cycle with dv=1:
  - The byte updates the CRC (reflected poly 32'hEDB88320) and is pushed into a 5-byte delay line. Count increments.
  - When count before the push is at least 5, the shifted-out byte is emitted with rx_valid_out=1.
  - rx_sof_out=1 on the first emitted byte.
  - Latency: payload byte k appears on rx_d_out 1 cycle after byte k+5 is sampled.
- DATA, first cycle with dv=0 (frame end):
  - Count below 5: no byte is emitted. rx_eof_out=1, rx_bad_out=1, rx_valid_out=0.
  - Otherwise the oldest delay-line byte is emitted with rx_valid_out=1 and rx_eof_out=1. The remaining 4 delay-line bytes are the FCS and are discarded.
  - rx_len_out = count-4.
  - rx_good_out=1 only if all of the following hold; otherwise rx_bad_out=1:
    - CRC residue = 32'hC704DD7B
    - no eth_rx_err_in was sampled during DATA
    - MIN_LEN <= count <= MAX_LEN
  - FSM -> IDLE.
- Error during DATA: eth_rx_err_in=1 sets a sticky error flag. Reception continues to the end of the frame.
- Oversize: when count would reach MAX_LEN+1, emit an abort (rx_eof_out=1, rx_valid_out=0, rx_bad_out=1) and go to DROP.
- DROP: ignore all bytes. dv=0 -> IDLE.
- rx_drop_cnt_out increments on every rx_bad_out pulse.
- Back-to-back frames: one dv=0 cycle between frames is sufficient. The status pulse and the IDLE decision happen in the same cycle.
- Reset mid-frame: outputs clear immediately and no eof is issued. The tail of the interrupted frame normally lands in DROP via IDLE. A tail byte equal to 8'h55 or 8'hD5 can still be misread as preamble/SFD, which is accepted behaviour.

Optional Feature:
Macro: ETH_RX_ADDR_FILTER_EN
- Defined:
  - On the cycle the 6th DATA byte is sampled (the cycle that would emit byte 0), the assembled destination MAC is compared with MAC_ADDR and with 48'hFFFFFFFFFFFF.
  - No match: byte 0 is suppressed, nothing is ever emitted for the frame, there is no status pulse, rx_drop_cnt_out is unchanged, and the FSM goes to DROP.
- Undefined: every frame is forwarded regardless of destination.

Decomposition:
- Package eth_pkg holds:
  - ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5
  - ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF, ETH_CRC_RESIDUE=32'hC704DD7B
  - ETH_BCAST_ADDR
  - FSM state encoding
- Sub-module eth_crc32_d8: purely combinational next-CRC function (32-bit crc in, 8-bit data in, 32-bit crc out). It is shared with the transmit path.

Test Plan:
1. 7x55, D5, 60 payload bytes, valid FCS -> 60 valid bytes in order, sof on byte 0, eof+good on byte 59, len=60, drop_cnt=0.
2. Same frame with FCS bit 0 flipped -> 60 bytes emitted, eof+bad, drop_cnt=1.
3. eth_rx_err_in=1 for one cycle at payload byte 20 -> eof+bad. Next clean frame -> good.
4. Runt of 40 payload + 4 FCS (valid CRC) -> eof+bad, len=40. 3-byte frame after SFD -> standalone eof+bad, no valid.
5. 1600-byte frame -> abort (eof=1, valid=0, bad=1) in the cycle after the 1519th byte is sampled. No further valid until the next SFD.
6. rst pulsed at payload byte 30 -> all outputs 0, no eof. Next frame good. With ETH_RX_ADDR_FILTER_EN: wrong destination -> no valid or status; broadcast destination -> good.
